// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for div_tick_timer and its sub-blocks.
//   state_e        : timer FSM states (IDLE, RUN)
//   MODE_ONESHOT   : mode value for a single expiry, then return to IDLE
//   MODE_PERIODIC  : mode value for automatic reload on every expiry
//   DIV_MIN_PHASE  : shortest div_clk high or low phase, in clk cycles, that
//                    the synchroniser is guaranteed to resolve into a tick
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int unsigned DIV_MIN_PHASE = 2;

endpackage : timer_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchroniser followed by a rising-edge detector. Turns a slow,
// asynchronous level (e.g. a divider tap) into a one-cycle pulse in the clk
// domain. The input must hold each level for at least two clk cycles.
// Ports:
//   clk   in   system clock
//   rst_  in   asynchronous active-low reset
//   d     in   asynchronous level input
//   rise  out  one-cycle pulse, two to three cycles after a rising edge of d
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst_,
    input  logic d,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: non-blocking assignments make the three flops shift as a true
    // pipeline; blocking ones would collapse the chain into a single stage.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only the second stage is trusted as metastability-free.
    assign rise = sync2_q & ~prev_q;

endmodule : sync_edge_det

// File: rtl/div_tick_timer.sv
// -----------------------------------------------------------------------------
// div_tick_timer
// Programmable down-counting timer clocked by ticks derived from the divided
// clock of clock_divider. div_clk is sampled as data, never used as a clock.
// Supports one-shot and periodic modes, with a sticky interrupt and overrun.
// Ports:
//   clk       in   system clock (same clock as clock_divider)
//   rst_      in   asynchronous active-low reset
//   div_clk   in   divided clock, treated as an asynchronous level
//   en        in   global enable; low freezes counting and ignores start
//   start     in   pulse: latch load_val/mode and begin or restart a run
//   stop      in   pulse: abort the run
//   mode      in   0 one-shot, 1 periodic; sampled with start
//   load_val  in   ticks per period; sampled with start; 0 never runs
//   irq_ack   in   pulse: clears irq and ovf
//   count     out  remaining ticks in the current period
//   busy      out  high while running
//   tick      out  one-cycle pulse per div_clk rising edge
//   irq       out  sticky expiry flag
//   ovf       out  sticky flag: expiry while irq was already set
// -----------------------------------------------------------------------------
module div_tick_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             div_clk,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             irq,
    output logic             ovf
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] shadow_load_q, shadow_load_d;
    logic             shadow_mode_q, shadow_mode_d;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic             expire;
    logic             load_nz;

    sync_edge_det u_tick_det (
        .clk  (clk),
        .rst_ (rst_),
        .d    (div_clk),
        .rise (tick)
    );

    assign load_nz = (load_val != '0);

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        shadow_load_d = shadow_load_q;
        shadow_mode_d = shadow_mode_q;
        irq_d         = irq_q;
        ovf_d         = ovf_q;
        expire        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && en && load_nz) begin
                    state_d       = ST_RUN;
                    count_d       = load_val;
                    shadow_load_d = load_val;
                    shadow_mode_d = mode;
                end
            end
            ST_RUN: begin
                // Priority: stop, then restart, then tick.
                if (stop) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (start && en) begin
                    if (load_nz) begin
                        count_d       = load_val;
                        shadow_load_d = load_val;
                        shadow_mode_d = mode;
                    end else begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end else if (tick && en) begin
                    // Expiry is detected at 1, so count never wraps below 0.
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        expire = 1'b1;
                        if (shadow_mode_q == MODE_ONESHOT) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end else begin
                            count_d = shadow_load_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        // Acknowledge first so a same-cycle expiry overrides it.
        if (irq_ack) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (expire) begin
            irq_d = 1'b1;
            ovf_d = ovf_d | irq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            shadow_load_q <= '0;
            shadow_mode_q <= 1'b0;
            irq_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            shadow_load_q <= shadow_load_d;
            shadow_mode_q <= shadow_mode_d;
            irq_q         <= irq_d;
            ovf_q         <= ovf_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign irq   = irq_q;
    assign ovf   = ovf_q;

endmodule : div_tick_timer
